// File: rtl/osd_char_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : osd_char_write_queue
// Description : Collects character writes from the OSD text writers, drops
//               writes that fall outside the text buffer or arrive while the
//               queue is full, and drains the rest into the character RAM at
//               one write per cycle. A fill engine can overwrite the whole
//               buffer with FILL_CHAR. Writes that arrive during a fill stay
//               queued and reach the RAM after the fill has finished.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_char_write_queue #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] FILL_CHAR  = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_we,
    input  logic [15:0] in_addr,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic        clear_done,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic [7:0]  drop_count
);

    localparam int             c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [16:0]    c_LIMIT = 17'(COLS * ROWS);
    localparam logic [16:0]    c_LAST  = c_LIMIT - 17'd1;
    localparam logic [c_AW:0]  c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // Queue storage and bookkeeping
    logic [15:0]       r_mem_addr [FIFO_DEPTH];
    logic [7:0]        r_mem_data [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic [c_AW:0]     w_count_next;

    logic [15:0]       r_fill_cnt;
    logic              r_clear_busy;
    logic              r_clear_done;
    logic              r_ram_we;
    logic [15:0]       r_ram_addr;
    logic [7:0]        r_ram_data;
    logic [7:0]        r_drop_count;

    logic              w_full;
    logic              w_empty;
    logic              w_in_range;
    logic              w_push;
    logic              w_reject;
    logic              w_pop;
    logic              w_start_clear;
    logic              w_fill_we;
    logic              w_fill_done;

    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_in_range = ({1'b0, in_addr} < c_LIMIT);
    // Fullness is judged before any same-cycle pop: there is no bypass path.
    assign w_push     = in_we && !w_full && w_in_range;
    assign w_reject   = in_we && (w_full || !w_in_range);

    // The fill has been fully presented to the RAM once the engine is back in
    // RUN while the busy flag is still set; that is the clear_done cycle.
    assign w_fill_done = (r_state == S_RUN) && r_clear_busy;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        w_state_next  = r_state;
        w_start_clear = 1'b0;
        w_pop         = 1'b0;
        w_fill_we     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (clear_req) begin
                    // Flush takes the cycle; nothing is popped.
                    w_start_clear = 1'b1;
                    w_state_next  = S_CLEAR;
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                end
            end
            S_CLEAR: begin
                // clear_req is ignored here; the sweep never restarts.
                w_fill_we = 1'b1;
                if ({1'b0, r_fill_cnt} == c_LAST) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    // Occupancy after this cycle's flush, push and pop
    always_comb begin
        w_count_next = r_count;
        if (w_start_clear) begin
            // Flush first, then keep a write accepted in the same cycle.
            w_count_next = (c_AW + 1)'(w_push);
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + 1'b1;
                2'b01:   w_count_next = r_count - 1'b1;
                default: w_count_next = r_count;
            endcase
        end
    end

    // Queue pointers and occupancy; pointers wrap modulo FIFO_DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_start_clear) begin
                // Empty the queue by catching the read pointer up.
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Queue storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= in_addr;
            r_mem_data[r_wr_ptr] <= in_data;
        end
    end

    // Fill address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
        end else if (w_start_clear) begin
            r_fill_cnt <= '0;
        end else if (w_fill_we) begin
            r_fill_cnt <= r_fill_cnt + 16'd1;
        end
    end

    // RAM write port: fill writes take priority, otherwise the popped entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
        end else if (w_fill_we) begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_fill_cnt;
            r_ram_data <= FILL_CHAR;
        end else if (w_pop) begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_mem_addr[r_rd_ptr];
            r_ram_data <= r_mem_data[r_rd_ptr];
        end else begin
            r_ram_we   <= 1'b0;
        end
    end

    // Busy stays up through the last visible fill write; done pulses after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= w_fill_done;
            if (w_start_clear) begin
                r_clear_busy <= 1'b1;
            end else if (w_fill_done) begin
                r_clear_busy <= 1'b0;
            end
        end
    end

    // Saturating count of rejected writes; flushed entries are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (w_reject && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign in_ready   = !w_full;
    assign clear_busy = r_clear_busy;
    assign clear_done = r_clear_done;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_data   = r_ram_data;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_osd_char_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_osd_char_write_queue
// Description : Directed, table-driven bench for osd_char_write_queue with
//               hand-written sequences for the clear engine, full queue,
//               flush-on-clear, reset during a clear and drop saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_char_write_queue;

    localparam int c_LIMIT = 1200;

    logic        clk;
    logic        rst_n;
    logic        in_we;
    logic [15:0] in_addr;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        clear_req;
    logic        clear_busy;
    logic        clear_done;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    osd_char_write_queue #(
        .COLS       (40),
        .ROWS       (30),
        .FIFO_DEPTH (8),
        .FILL_CHAR  (8'h20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_we      (in_we),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        logic        exp_ready;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_we     = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        clear_req = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic we, input logic [15:0] a, input logic [7:0] d);
        in_we   = we;
        in_addr = a;
        in_data = d;
    endtask

    initial begin
        int bad;
        logic [7:0] d;

        // ---------------- reset values ----------------
        do_reset();
        chk("reset_ram_we",   32'(ram_we),     32'd0);
        chk("reset_ram_addr", 32'(ram_addr),   32'd0);
        chk("reset_ram_data", 32'(ram_data),   32'd0);
        chk("reset_busy",     32'(clear_busy), 32'd0);
        chk("reset_done",     32'(clear_done), 32'd0);
        chk("reset_drop",     32'(drop_count), 32'd0);
        chk("reset_ready",    32'(in_ready),   32'd1);

        // ---------------- table: single writes and range checks ----------------
        //            we  addr      data   exp_we exp_addr exp_data rdy drop
        vecs[0]  = '{1'b1, 16'd5,    8'h41, 1'b0, 16'd0,    8'h00, 1'b1, 8'd0};
        vecs[1]  = '{1'b0, 16'd0,    8'h00, 1'b1, 16'd5,    8'h41, 1'b1, 8'd0};
        vecs[2]  = '{1'b0, 16'd0,    8'h00, 1'b0, 16'd0,    8'h00, 1'b1, 8'd0};
        vecs[3]  = '{1'b1, 16'd1200, 8'h42, 1'b0, 16'd0,    8'h00, 1'b1, 8'd1};
        vecs[4]  = '{1'b1, 16'd1199, 8'h43, 1'b0, 16'd0,    8'h00, 1'b1, 8'd1};
        vecs[5]  = '{1'b0, 16'd0,    8'h00, 1'b1, 16'd1199, 8'h43, 1'b1, 8'd1};
        vecs[6]  = '{1'b1, 16'hFFFF, 8'h44, 1'b0, 16'd0,    8'h00, 1'b1, 8'd2};
        vecs[7]  = '{1'b1, 16'd10,   8'h45, 1'b0, 16'd0,    8'h00, 1'b1, 8'd2};
        vecs[8]  = '{1'b1, 16'd11,   8'h46, 1'b1, 16'd10,   8'h45, 1'b1, 8'd2};
        vecs[9]  = '{1'b0, 16'd0,    8'h00, 1'b1, 16'd11,   8'h46, 1'b1, 8'd2};
        vecs[10] = '{1'b0, 16'd0,    8'h00, 1'b0, 16'd0,    8'h00, 1'b1, 8'd2};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].data);
            step();
            chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("vec%0d_ram_data", i), 32'(ram_data), 32'(vecs[i].exp_data));
            end
            chk($sformatf("vec%0d_ready", i), 32'(in_ready),   32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_drop", i),  32'(drop_count), 32'(vecs[i].exp_drop));
        end
        drive(1'b0, 16'd0, 8'h00);

        // ---------------- clear sweep with queue filled to overflow ----------------
        do_reset();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("clr_entry_busy",  32'(clear_busy), 32'd1);
        chk("clr_entry_ramwe", 32'(ram_we),     32'd0);
        bad = 0;
        for (int c = 0; c < c_LIMIT; c++) begin
            if (c < 10) drive(1'b1, 16'(100 + c), 8'(8'h61 + c));
            else        drive(1'b0, 16'd0, 8'h00);
            step();
            if (!(ram_we === 1'b1 && ram_addr === 16'(c) && ram_data === 8'h20 &&
                  clear_busy === 1'b1 && clear_done === 1'b0)) begin
                if (bad == 0) $display("first bad fill cycle %0d: we=%0b addr=%0d data=%0h busy=%0b done=%0b",
                                       c, ram_we, ram_addr, ram_data, clear_busy, clear_done);
                bad++;
            end
            if (c == 6) chk("full_ready_after7", 32'(in_ready), 32'd1);
            if (c == 7) chk("full_ready_after8", 32'(in_ready), 32'd0);
            if (c == 9) chk("full_drop_after10", 32'(drop_count), 32'd2);
        end
        chk("fill_bad_cycles", 32'(bad), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("drain%0d_we", k),   32'(ram_we),   32'd1);
            chk($sformatf("drain%0d_addr", k), 32'(ram_addr), 32'(100 + k));
            d = 8'h61 + 8'(k);
            chk($sformatf("drain%0d_data", k), 32'(ram_data), 32'(d));
            chk($sformatf("drain%0d_done", k), 32'(clear_done), (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("drain%0d_busy", k), 32'(clear_busy), 32'd0);
        end
        step();
        chk("drain_end_we",    32'(ram_we),     32'd0);
        chk("drain_end_ready", 32'(in_ready),   32'd1);
        chk("drain_end_drop",  32'(drop_count), 32'd2);

        // ---------------- clear with simultaneous write; flushed entry ----------------
        do_reset();
        drive(1'b1, 16'd20, 8'h70);
        step();
        drive(1'b1, 16'd21, 8'h71);
        step();
        chk("sim_w0_addr", 32'(ram_addr), 32'd20);
        drive(1'b1, 16'd22, 8'h72);
        step();
        chk("sim_w1_addr", 32'(ram_addr), 32'd21);
        clear_req = 1'b1;
        drive(1'b1, 16'd7, 8'h5A);
        step();
        clear_req = 1'b0;
        drive(1'b0, 16'd0, 8'h00);
        chk("sim_entry_ramwe", 32'(ram_we),     32'd0);
        chk("sim_entry_busy",  32'(clear_busy), 32'd1);
        bad = 0;
        for (int c = 0; c < c_LIMIT; c++) begin
            // A second request mid-sweep must not restart the fill.
            clear_req = (c == 500);
            step();
            if (!(ram_we === 1'b1 && ram_addr === 16'(c) && ram_data === 8'h20)) bad++;
        end
        clear_req = 1'b0;
        chk("sim_fill_bad_cycles", 32'(bad), 32'd0);
        step();
        chk("sim_z_we",   32'(ram_we),     32'd1);
        chk("sim_z_addr", 32'(ram_addr),   32'd7);
        chk("sim_z_data", 32'(ram_data),   32'h5A);
        chk("sim_z_done", 32'(clear_done), 32'd1);
        step();
        chk("sim_after_we",   32'(ram_we),     32'd0);
        chk("sim_after_done", 32'(clear_done), 32'd0);
        chk("sim_drop",       32'(drop_count), 32'd0);

        // ---------------- reset in the middle of a clear ----------------
        do_reset();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int c = 0; c <= 300; c++) step();
        chk("mid_addr_before_rst", 32'(ram_addr), 32'd300);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",    32'(ram_we),     32'd0);
        chk("mid_rst_addr",  32'(ram_addr),   32'd0);
        chk("mid_rst_data",  32'(ram_data),   32'd0);
        chk("mid_rst_busy",  32'(clear_busy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),   32'd1);
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 1300; c++) begin
            step();
            if (ram_we !== 1'b0 || clear_done !== 1'b0 || clear_busy !== 1'b0) bad++;
        end
        chk("mid_quiet_cycles", 32'(bad), 32'd0);
        drive(1'b1, 16'd3, 8'h78);
        step();
        drive(1'b0, 16'd0, 8'h00);
        chk("mid_new_wr_lat1", 32'(ram_we), 32'd0);
        step();
        chk("mid_new_wr_we",   32'(ram_we),   32'd1);
        chk("mid_new_wr_addr", 32'(ram_addr), 32'd3);

        // ---------------- drop counter saturation ----------------
        do_reset();
        drive(1'b1, 16'hFFFF, 8'h00);
        for (int c = 0; c < 260; c++) step();
        drive(1'b0, 16'd0, 8'h00);
        chk("sat_drop",  32'(drop_count), 32'd255);
        chk("sat_ramwe", 32'(ram_we),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
